// File: rtl/store_data_rmw_pkg.sv
// Shared definitions for the store read-modify-write path: type codes,
// FSM state encoding and the latched request payload.
package store_data_rmw_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned CNT_W   = 8;

  // Access type codes, common with the load unit
  localparam logic [1:0] TYPE_WORD = 2'd0;
  localparam logic [1:0] TYPE_HALF = 2'd1;
  localparam logic [1:0] TYPE_BYTE = 2'd2;
  localparam logic [1:0] TYPE_ILL  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      st_type;
  } st_req_t;

  // True when the request cannot be performed (misaligned or illegal type)
  function automatic logic st_bad(input logic [1:0] st_type, input logic [1:0] addr_lo);
    case (st_type)
      TYPE_WORD: st_bad = (addr_lo != 2'b00);
      TYPE_HALF: st_bad = addr_lo[0];
      TYPE_BYTE: st_bad = 1'b0;
      default:   st_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the addressed byte/half lane of a memory word with store data
// (little-endian lanes); a word store passes the new data through.
module store_lane_merge
  import store_data_rmw_pkg::*;
(
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] new_data,
  input  logic [1:0]      st_type,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    case (st_type)
      TYPE_HALF: begin
        if (addr_lo[1]) merged_c[31:16] = new_data[15:0];
        else            merged_c[15:0]  = new_data[15:0];
      end
      TYPE_BYTE: merged_c[{addr_lo, 3'b000} +: 8] = new_data[7:0];
      default:   merged_c = new_data;
    endcase
  end

endmodule

// File: rtl/store_data_rmw.sv
// Store unit: word stores write directly, sub-word stores read the containing
// word, merge the addressed lane and write it back. Errors end without access.
module store_data_rmw
  import store_data_rmw_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_data,
  input  logic [1:0]         req_type,
  output logic               mem_rd_en,
  input  logic [XLEN-1:0]    mem_rd_data,
  input  logic               mem_rd_valid,
  output logic               mem_wr_en,
  output logic [XLEN-1:0]    mem_wr_data,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               done,
  output logic               err
);

  logic [2:0]      state_q, state_d;
  st_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] wr_data_d;
  logic [XLEN-1:0] merged_c;
  logic            ready_d, rd_en_d, wr_en_d, done_d, err_d;

  store_lane_merge u_merge (
    .old_word (mem_rd_data),
    .new_data (req_q.data),
    .st_type  (req_q.st_type),
    .addr_lo  (req_q.addr[1:0]),
    .merged_c (merged_c)
  );

  // Latched address register drives the memory address directly
  assign mem_addr = req_q.addr[XLEN-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      mem_wr_data <= '0;
      req_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_wr_data <= wr_data_d;
      req_ready   <= ready_d;
      mem_rd_en   <= rd_en_d;
      mem_wr_en   <= wr_en_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // Next state plus registered-output decodes of the next state
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    wr_data_d = mem_wr_data;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d.addr    = req_addr;
          req_d.data    = req_data;
          req_d.st_type = req_type;
          if (st_bad(req_type, req_addr[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (req_type == TYPE_WORD) begin
            state_d   = ST_WRITE;
            wr_data_d = req_data;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Returned data takes priority over a timeout in the same cycle
        if (mem_rd_valid) begin
          wr_data_d = merged_c;
          state_d   = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(RD_TIMEOUT)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    rd_en_d = (state_d == ST_READ);
    wr_en_d = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_store_data_rmw.sv
// Scoreboard bench for store_data_rmw: expected writes and completions are
// queued per request and compared when the DUT strobes them.
module tb_store_data_rmw;
  import store_data_rmw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_type = '0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_valid = 1'b0;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [29:0] mem_addr;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [61:0] exp_wr_q[$];
  logic        exp_err_q[$];
  logic [61:0] mon_wr;
  logic        mon_err;

  store_data_rmw #(.RD_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_addr(mem_addr),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe and completion pulse must match a queued expectation
  always @(negedge clk) begin
    if (mem_wr_en) begin
      tests++;
      if (exp_wr_q.size() == 0) begin
        fails++;
        $display("FAIL sb_write: unexpected write addr=%h data=%h, required none", mem_addr, mem_wr_data);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        if ({mem_addr, mem_wr_data} !== mon_wr) begin
          fails++;
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wr_data, mon_wr[61:32], mon_wr[31:0]);
        end
      end
    end
    if (done) begin
      tests++;
      if (exp_err_q.size() == 0) begin
        fails++;
        $display("FAIL sb_done: unexpected done err=%b, required none", err);
      end else begin
        mon_err = exp_err_q.pop_front();
        if (err !== mon_err) begin
          fails++;
          $display("FAIL sb_err: got %b, required %b", err, mon_err);
        end
      end
    end
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] t, input logic [1:0] a);
    logic [31:0] mask, ins;
    if (t == TYPE_BYTE) begin
      mask = 32'h0000_00FF << (8 * a);
      ins  = (d & 32'h0000_00FF) << (8 * a);
    end else begin
      mask = 32'h0000_FFFF << (16 * a[1]);
      ins  = (d & 32'h0000_FFFF) << (16 * a[1]);
    end
    return (old & ~mask) | ins;
  endfunction

  // Presents one request, plays the memory side, records strobe latencies from accept
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                          input int k, input logic [31:0] mw, input bit stray,
                          output int t0, output int lat_rd, output int lat_wr,
                          output int lat_done, output int n_rd, output int n_wr);
    int rel;
    lat_rd = -1; lat_wr = -1; lat_done = -1; n_rd = 0; n_wr = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_type = t; t0 = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      mem_rd_valid = 1'b0;
      if (mem_rd_en) begin n_rd++; lat_rd = rel; end
      if (stray && mem_rd_en) begin mem_rd_valid = 1'b1; mem_rd_data = ~mw; end
      if (k > 0 && lat_rd >= 0 && rel == lat_rd + k) begin
        mem_rd_valid = 1'b1; mem_rd_data = mw;
      end
      if (mem_wr_en) begin n_wr++; lat_wr = rel; end
      if (done) begin lat_done = rel; break; end
    end
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({req_ready, mem_rd_en, mem_wr_en, done, err} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 10000", {req_ready, mem_rd_en, mem_wr_en, done, err});
    end
    tests++;
    if (mem_wr_data !== 32'h0 || mem_addr !== 30'h0) begin
      fails++;
      $display("FAIL reset_data: got wr_data=%h addr=%h, required 0/0", mem_wr_data, mem_addr);
    end
  endtask

  task automatic test_word();
    int t0, lr, lw, ld, nr, nw;
    exp_wr_q.push_back({30'h40, 32'hDEADBEEF});
    exp_err_q.push_back(1'b0);
    do_store(32'h100, 32'hDEADBEEF, TYPE_WORD, 0, 32'h0, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (nr !== 0 || lw !== 1 || ld !== 2) begin
      fails++;
      $display("FAIL word_timing: got rd=%0d wr@%0d done@%0d, required rd=0 wr@1 done@2", nr, lw, ld);
    end
  endtask

  task automatic test_byte();
    int t0, lr, lw, ld, nr, nw;
    exp_wr_q.push_back({30'h40, 32'hAA223344});
    exp_err_q.push_back(1'b0);
    do_store(32'h103, 32'h000000AA, TYPE_BYTE, 1, 32'h11223344, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (lr !== 1 || lw !== 3 || ld !== 4) begin
      fails++;
      $display("FAIL byte_timing: got rd@%0d wr@%0d done@%0d, required 1/3/4", lr, lw, ld);
    end
  endtask

  task automatic test_half();
    int t0, lr, lw, ld, nr, nw;
    exp_wr_q.push_back({30'h40, 32'hCAFE3344});
    exp_err_q.push_back(1'b0);
    do_store(32'h102, 32'h0000CAFE, TYPE_HALF, 3, 32'h11223344, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (lr !== 1 || lw !== 5 || ld !== 6) begin
      fails++;
      $display("FAIL half_timing: got rd@%0d wr@%0d done@%0d, required 1/5/6", lr, lw, ld);
    end
  endtask

  task automatic test_errors();
    int t0, lr, lw, ld, nr, nw;
    logic [31:0] addrs[3] = '{32'h101, 32'h102, 32'h200};
    logic [1:0]  typs[3]  = '{TYPE_HALF, TYPE_WORD, TYPE_ILL};
    for (int i = 0; i < 3; i++) begin
      exp_err_q.push_back(1'b1);
      do_store(addrs[i], 32'h12345678, typs[i], 0, 32'h0, 1'b0, t0, lr, lw, ld, nr, nw);
      tests++;
      if (nr !== 0 || nw !== 0 || ld !== 1) begin
        fails++;
        $display("FAIL err_case%0d: got rd=%0d wr=%0d done@%0d, required 0/0/1", i, nr, nw, ld);
      end
    end
  endtask

  task automatic test_timeout();
    int t0, lr, lw, ld, nr, nw;
    exp_err_q.push_back(1'b1);
    do_store(32'h101, 32'h00000012, TYPE_BYTE, 0, 32'h0, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (nr !== 1 || nw !== 0 || ld !== 17) begin
      fails++;
      $display("FAIL timeout: got rd=%0d wr=%0d done@%0d, required 1/0/17", nr, nw, ld);
    end
    exp_wr_q.push_back({30'h40, 32'h55661288});
    exp_err_q.push_back(1'b0);
    do_store(32'h101, 32'h00000012, TYPE_BYTE, 15, 32'h55667788, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (nw !== 1 || lw !== 17 || ld !== 18) begin
      fails++;
      $display("FAIL timeout_edge: got wr=%0d wr@%0d done@%0d, required 1/17/18", nw, lw, ld);
    end
  endtask

  task automatic test_stray_valid();
    int t0, lr, lw, ld, nr, nw;
    exp_wr_q.push_back({30'h3FF, 32'hA1B2BEEF});
    exp_err_q.push_back(1'b0);
    do_store(32'hFFC, 32'h0000BEEF, TYPE_HALF, 2, 32'hA1B2C3D4, 1'b1, t0, lr, lw, ld, nr, nw);
    tests++;
    if (lw !== 4 || ld !== 5) begin
      fails++;
      $display("FAIL stray_valid: got wr@%0d done@%0d, required 4/5", lw, ld);
    end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b, lr, lw, ld, ldb, nr, nw;
    exp_wr_q.push_back({30'h0123, 32'h01020304});
    exp_err_q.push_back(1'b0);
    do_store(32'h48C, 32'h01020304, TYPE_WORD, 0, 32'h0, 1'b0, t0a, lr, lw, ld, nr, nw);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_in_done: got %b, required 0", req_ready);
    end
    exp_wr_q.push_back({30'h0124, 32'h99887766});
    exp_err_q.push_back(1'b0);
    do_store(32'h490, 32'h99887766, TYPE_WORD, 0, 32'h0, 1'b0, t0b, lr, lw, ldb, nr, nw);
    tests++;
    if (t0b !== t0a + ld + 1 || ldb !== 2) begin
      fails++;
      $display("FAIL back_to_back: got accept gap %0d done@%0d, required %0d/2", t0b - t0a, ldb, ld + 1);
    end
  endtask

  task automatic test_random();
    int t0, lr, lw, ld, nr, nw, k;
    logic [31:0] a, d, mw;
    logic [1:0]  t;
    for (int i = 0; i < 16; i++) begin
      t  = (($urandom_range(0, 1)) != 0) ? TYPE_BYTE : TYPE_HALF;
      a  = $urandom;
      if (t == TYPE_HALF) a[0] = 1'b0;
      d  = $urandom;
      mw = $urandom;
      k  = $urandom_range(1, 4);
      exp_wr_q.push_back({a[31:2], ref_merge(mw, d, t, a[1:0])});
      exp_err_q.push_back(1'b0);
      do_store(a, d, t, k, mw, 1'b0, t0, lr, lw, ld, nr, nw);
      tests++;
      if (ld !== 3 + k || nw !== 1) begin
        fails++;
        $display("FAIL rand%0d: got done@%0d wr=%0d, required done@%0d wr=1", i, ld, nw, 3 + k);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int t0, lr, lw, ld, nr, nw, bad;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h204; req_data = 32'h77; req_type = TYPE_BYTE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, mem_rd_en, mem_wr_en, done, err} !== 5'b10000 || mem_wr_data !== 32'h0 || mem_addr !== 30'h0) begin
      fails++;
      $display("FAIL async_reset: got ctrl=%b wr_data=%h addr=%h, required 10000/0/0",
               {req_ready, mem_rd_en, mem_wr_en, done, err}, mem_wr_data, mem_addr);
    end
    mem_rd_valid = 1'b1; mem_rd_data = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (mem_wr_en || done || mem_rd_en) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL post_reset_quiet: got %0d strobe cycles, required 0", bad);
    end
    exp_wr_q.push_back({30'h0081, 32'hC0FFEE00});
    exp_err_q.push_back(1'b0);
    do_store(32'h204, 32'hC0FFEE00, TYPE_WORD, 0, 32'h0, 1'b0, t0, lr, lw, ld, nr, nw);
    tests++;
    if (lw !== 1 || ld !== 2) begin
      fails++;
      $display("FAIL after_reset_sw: got wr@%0d done@%0d, required 1/2", lw, ld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_timeout();
    test_stray_valid();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_wr_q.size() != 0 || exp_err_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d writes / %0d completions outstanding, required 0/0",
               exp_wr_q.size(), exp_err_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
